// File: rtl/seq_load_counter.sv
// Periodic load/step sequencer: a three-state machine reloads an up/down counter
// once per period and steps it on every enabled cycle for the rest of the period.
module seq_load_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PERIOD   = 4,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SATURATE = 0,
    localparam int unsigned PW      = $clog2(PERIOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] s,
    output logic [PW-1:0]    phase,
    output logic             load_pulse,
    output logic             period_done,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } state_e;

    localparam logic [WIDTH:0] StepExt   = (WIDTH + 1)'(STEP);
    localparam logic [PW-1:0]  LastPhase = PW'(PERIOD - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             stop_pend_q, stop_pend_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   sum_up, sum_dn;
    logic [WIDTH-1:0] step_val;
    logic             step_ovf;

    // Step arithmetic in WIDTH+1 bits so the top bit is the carry/borrow.
    always_comb begin
        sum_up = {1'b0, s_q} + StepExt;
        sum_dn = {1'b0, s_q} - StepExt;
        if (!dir) begin
            step_ovf = sum_up[WIDTH];
            step_val = (SATURATE != 0 && step_ovf) ? '1 : sum_up[WIDTH-1:0];
        end else begin
            step_ovf = sum_dn[WIDTH];
            step_val = (SATURATE != 0 && step_ovf) ? '0 : sum_dn[WIDTH-1:0];
        end
    end

    // Next-state logic; en=0 holds everything except leaving IDLE on start.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        phase_d     = phase_q;
        stop_pend_d = stop_pend_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (en) ovf_d = 1'b0;
                if (start) begin
                    state_d     = StLoad;
                    // start+stop together runs exactly one period
                    stop_pend_d = stop;
                end
            end
            StLoad: begin
                if (en) begin
                    s_d     = load_val;
                    phase_d = PW'(1);
                    ovf_d   = 1'b0;
                    state_d = StRun;
                    if (stop) stop_pend_d = 1'b1;
                end
            end
            StRun: begin
                if (en) begin
                    s_d   = step_val;
                    ovf_d = step_ovf;
                    if (stop) stop_pend_d = 1'b1;
                    if (phase_q == LastPhase) begin
                        phase_d = '0;
                        if (stop_pend_q || stop) begin
                            state_d     = StIdle;
                            stop_pend_d = 1'b0;
                        end else begin
                            state_d = StLoad;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            s_q         <= '0;
            phase_q     <= '0;
            stop_pend_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            phase_q     <= phase_d;
            stop_pend_q <= stop_pend_d;
            ovf_q       <= ovf_d;
        end
    end

    // Registered values out, status decoded from state.
    always_comb begin
        s           = s_q;
        phase       = phase_q;
        ovf         = ovf_q;
        busy        = (state_q != StIdle);
        load_pulse  = (state_q == StLoad);
        period_done = (state_q == StRun) && (phase_q == LastPhase) && en;
    end

endmodule

// File: tb/tb_seq_load_counter.sv
// Bench for seq_load_counter: a wrapping and a saturating instance share stimulus
// and are checked against a position-in-period reference model.
module tb_seq_load_counter;

    localparam int P    = 4;
    localparam int STEP = 1;
    localparam int MAXV = 255;

    logic clk, rst, start, stop, en, dir;
    logic [7:0] load_val;
    logic [7:0] s_a, s_b;
    logic [1:0] phase_a, phase_b;
    logic lp_a, lp_b, pd_a, pd_b, ovf_a, ovf_b, busy_a, busy_b;

    int tests = 0;
    int fails = 0;

    // Reference model: busy flag, position in period (0 = load cycle), values.
    bit m_busy, m_pend, m_ovf_w, m_ovf_b;
    int m_pos, m_s_w, m_s_b;

    seq_load_counter #(.WIDTH(8), .PERIOD(P), .STEP(STEP), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .dir(dir),
        .load_val(load_val), .s(s_a), .phase(phase_a), .load_pulse(lp_a),
        .period_done(pd_a), .ovf(ovf_a), .busy(busy_a)
    );

    seq_load_counter #(.WIDTH(8), .PERIOD(P), .STEP(STEP), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .dir(dir),
        .load_val(load_val), .s(s_b), .phase(phase_b), .load_pulse(lp_b),
        .period_done(pd_b), .ovf(ovf_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_phase();
        return m_busy ? 2'(m_pos) : 2'd0;
    endfunction
    function automatic logic exp_lp();
        return m_busy && m_pos == 0;
    endfunction
    function automatic logic exp_pd();
        return m_busy && m_pos == P - 1 && en;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_pend = 0; m_ovf_w = 0; m_ovf_b = 0;
        m_pos = 0; m_s_w = 0; m_s_b = 0;
    endtask

    // Advance model by one clock using the inputs currently applied, then wait for the edge.
    task automatic tick();
        bit nb = m_busy, np = m_pend, now = m_ovf_w, nob = m_ovf_b;
        int npos = m_pos, nsw = m_s_w, nsb = m_s_b, r;
        if (!m_busy) begin
            if (en) begin now = 0; nob = 0; end
            if (start) begin nb = 1; npos = 0; np = stop; end
        end else if (en) begin
            if (stop) np = 1;
            if (m_pos == 0) begin
                nsw = load_val; nsb = load_val; now = 0; nob = 0; npos = 1;
            end else begin
                r   = dir ? m_s_w - STEP : m_s_w + STEP;
                now = (r < 0) || (r > MAXV);
                nsw = (r + MAXV + 1) % (MAXV + 1);
                r   = dir ? m_s_b - STEP : m_s_b + STEP;
                nob = (r < 0) || (r > MAXV);
                nsb = (r < 0) ? 0 : (r > MAXV) ? MAXV : r;
                if (m_pos == P - 1) begin
                    npos = 0;
                    if (m_pend || stop) begin nb = 0; np = 0; end
                end else begin
                    npos = m_pos + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_busy = nb; m_pend = np; m_ovf_w = now; m_ovf_b = nob;
        m_pos = npos; m_s_w = nsw; m_s_b = nsb;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; stop = 0; en = 1; dir = 0; load_val = 8'h00;
        #3;
        tests++; if (s_a !== 8'h00) begin fails++; $display("FAIL reset_s: got %h expected 00", s_a); end
        tests++; if (phase_a !== 2'd0) begin fails++; $display("FAIL reset_phase: got %0d expected 0", phase_a); end
        tests++; if (busy_a !== 1'b0 || lp_a !== 1'b0 || pd_a !== 1'b0 || ovf_a !== 1'b0) begin
            fails++; $display("FAIL reset_flags: got busy=%b lp=%b pd=%b ovf=%b expected 0", busy_a, lp_a, pd_a, ovf_a);
        end
        model_reset();
        @(negedge clk); rst = 0;
    endtask

    task automatic test_ramp();
        load_val = 8'h10; dir = 0; en = 1; start = 1;
        tick(); start = 0;
        tests++; if (lp_a !== 1'b1 || phase_a !== 2'd0) begin
            fails++; $display("FAIL ramp_load: got lp=%b phase=%0d expected lp=1 phase=0", lp_a, phase_a);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            tests++; if (s_a !== 8'(m_s_w)) begin fails++; $display("FAIL ramp_s[%0d]: got %h expected %h", i, s_a, 8'(m_s_w)); end
            tests++; if (phase_a !== exp_phase()) begin fails++; $display("FAIL ramp_phase[%0d]: got %0d expected %0d", i, phase_a, exp_phase()); end
            tests++; if (lp_a !== exp_lp() || pd_a !== exp_pd()) begin
                fails++; $display("FAIL ramp_pulses[%0d]: got lp=%b pd=%b expected lp=%b pd=%b", i, lp_a, pd_a, exp_lp(), exp_pd());
            end
            if (i == 0) begin
                tests++; if (s_a !== 8'h10) begin fails++; $display("FAIL ramp_first: got %h expected 10", s_a); end
            end
            if (i == 3) begin
                tests++; if (s_a !== 8'h13 || lp_a !== 1'b1) begin fails++; $display("FAIL ramp_reload: got s=%h lp=%b expected s=13 lp=1", s_a, lp_a); end
            end
        end
    endtask

    task automatic test_wrap();
        load_val = 8'hFE; dir = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++; if (s_a !== 8'(m_s_w) || ovf_a !== m_ovf_w) begin
                fails++; $display("FAIL wrap[%0d]: got s=%h ovf=%b expected s=%h ovf=%b", i, s_a, ovf_a, 8'(m_s_w), m_ovf_w);
            end
            tests++; if (s_b !== 8'(m_s_b) || ovf_b !== m_ovf_b) begin
                fails++; $display("FAIL wrap_sat[%0d]: got s=%h ovf=%b expected s=%h ovf=%b", i, s_b, ovf_b, 8'(m_s_b), m_ovf_b);
            end
        end
    endtask

    task automatic test_saturate();
        load_val = 8'h01; dir = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++; if (s_b !== 8'(m_s_b) || ovf_b !== m_ovf_b) begin
                fails++; $display("FAIL sat_down[%0d]: got s=%h ovf=%b expected s=%h ovf=%b", i, s_b, ovf_b, 8'(m_s_b), m_ovf_b);
            end
            tests++; if (s_a !== 8'(m_s_w) || ovf_a !== m_ovf_w) begin
                fails++; $display("FAIL borrow[%0d]: got s=%h ovf=%b expected s=%h ovf=%b", i, s_a, ovf_a, 8'(m_s_w), m_ovf_w);
            end
        end
        dir = 0;
    endtask

    task automatic test_freeze();
        logic [7:0] held;
        int n = 0;
        load_val = 8'h40;
        while (!(m_busy && m_pos == 2) && n < 12) begin tick(); n++; end
        tests++; if (phase_a !== 2'd2) begin fails++; $display("FAIL freeze_reach: got phase=%0d expected 2", phase_a); end
        held = s_a;
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (s_a !== held || phase_a !== 2'd2 || ovf_a !== m_ovf_w) begin
                fails++; $display("FAIL freeze[%0d]: got s=%h phase=%0d ovf=%b expected s=%h phase=2 ovf=%b", i, s_a, phase_a, ovf_a, held, m_ovf_w);
            end
            tests++; if (pd_a !== 1'b0 || lp_a !== 1'b0) begin fails++; $display("FAIL freeze_pd[%0d]: got pd=%b lp=%b expected 0", i, pd_a, lp_a); end
        end
        en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (s_a !== 8'(m_s_w) || phase_a !== exp_phase() || lp_a !== exp_lp()) begin
                fails++; $display("FAIL unfreeze[%0d]: got s=%h phase=%0d lp=%b expected s=%h phase=%0d lp=%b", i, s_a, phase_a, lp_a, 8'(m_s_w), exp_phase(), exp_lp());
            end
        end
    endtask

    task automatic test_stop();
        int n = 0;
        load_val = 8'h10; dir = 0;
        while (!(m_busy && m_pos == 0) && n < 12) begin tick(); n++; end
        tick();
        stop = 1; tick(); stop = 0;
        n = 0;
        while (busy_a === 1'b1 && n < 10) begin
            tick(); n++;
            tests++; if (busy_a !== m_busy) begin fails++; $display("FAIL stop_busy: got %b expected %b", busy_a, m_busy); end
        end
        tests++; if (busy_a !== 1'b0 || s_a !== 8'h13) begin fails++; $display("FAIL stop_end: got busy=%b s=%h expected busy=0 s=13", busy_a, s_a); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (busy_a !== 1'b0 || s_a !== 8'h13 || phase_a !== 2'd0) begin
                fails++; $display("FAIL stop_idle[%0d]: got busy=%b s=%h phase=%0d expected busy=0 s=13 phase=0", i, busy_a, s_a, phase_a);
            end
        end
        start = 1; tick(); start = 0;
        tests++; if (lp_a !== 1'b1 || busy_a !== 1'b1) begin fails++; $display("FAIL restart: got lp=%b busy=%b expected 1 1", lp_a, busy_a); end
    endtask

    task automatic test_start_stop();
        int n = 0;
        int busy_cycles = 0;
        stop = 1; tick(); stop = 0;
        while (m_busy && n < 10) begin tick(); n++; end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL ss_idle: got busy=%b expected 0", busy_a); end
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        n = 0;
        while (busy_a === 1'b1 && n < 20) begin busy_cycles++; tick(); n++; end
        tests++; if (busy_cycles != P) begin fails++; $display("FAIL ss_period: got %0d busy cycles expected %0d", busy_cycles, P); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL ss_stay_idle[%0d]: got busy=%b expected 0", i, busy_a); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            en       = ($urandom_range(0, 3) != 0);
            dir      = 1'($urandom_range(0, 1));
            load_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) load_val = $urandom_range(0, 1) ? 8'hFF : 8'h00;
            tick();
            tests++; if (s_a !== 8'(m_s_w) || ovf_a !== m_ovf_w) begin
                fails++; $display("FAIL rnd_wrap[%0d]: got s=%h ovf=%b expected s=%h ovf=%b", i, s_a, ovf_a, 8'(m_s_w), m_ovf_w);
            end
            tests++; if (s_b !== 8'(m_s_b) || ovf_b !== m_ovf_b) begin
                fails++; $display("FAIL rnd_sat[%0d]: got s=%h ovf=%b expected s=%h ovf=%b", i, s_b, ovf_b, 8'(m_s_b), m_ovf_b);
            end
            tests++; if (phase_a !== exp_phase() || busy_a !== m_busy || lp_a !== exp_lp() || pd_a !== exp_pd()) begin
                fails++; $display("FAIL rnd_ctrl[%0d]: got phase=%0d busy=%b lp=%b pd=%b expected phase=%0d busy=%b lp=%b pd=%b",
                                  i, phase_a, busy_a, lp_a, pd_a, exp_phase(), m_busy, exp_lp(), exp_pd());
            end
        end
        start = 0; stop = 0; en = 1; dir = 0;
    endtask

    task automatic test_async_reset();
        int n = 0;
        if (!m_busy) begin start = 1; tick(); start = 0; end
        while (!(m_busy && m_pos == 2) && n < 12) begin tick(); n++; end
        #2 rst = 1;
        #1;
        tests++; if (s_a !== 8'h00 || s_b !== 8'h00 || phase_a !== 2'd0 || busy_a !== 1'b0) begin
            fails++; $display("FAIL async_rst: got s=%h/%h phase=%0d busy=%b expected 00/00 0 0", s_a, s_b, phase_a, busy_a);
        end
        model_reset();
        @(negedge clk); rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (busy_a !== 1'b0 || lp_a !== 1'b0 || s_a !== 8'h00) begin
                fails++; $display("FAIL post_rst_idle[%0d]: got busy=%b lp=%b s=%h expected 0 0 00", i, busy_a, lp_a, s_a);
            end
        end
        start = 1; tick(); start = 0;
        tests++; if (lp_a !== 1'b1) begin fails++; $display("FAIL post_rst_start: got lp=%b expected 1", lp_a); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_wrap();
        test_saturate();
        test_freeze();
        test_stop();
        test_start_stop();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
